// File: rtl/uart_rx_pkg.sv
// Shared types and parameter helpers for the 8N1 UART receiver.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

  // Clocks per oversample tick; the transmitter uses the same derivation.
  function automatic int calc_div(input int clock_frequency, input int baud_rate,
                                  input int oversample);
    return clock_frequency / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte output handshake and status of the UART receiver.
interface uart_rx_if;
  logic [7:0] RxDataOutput;
  logic       RxValid;
  logic       RxReady;
  logic       RxFrameError;
  logic       RxOverrun;
  logic       RxBusy;

  modport master (
    output RxDataOutput, RxValid, RxFrameError, RxOverrun, RxBusy,
    input  RxReady
  );

  modport slave (
    input  RxDataOutput, RxValid, RxFrameError, RxOverrun, RxBusy,
    output RxReady
  );
endinterface

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: pulses Tick every DIV clocks, held at zero by Clear.
module uart_rx_tick_gen #(
  parameter int DIV = 10
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  output logic Tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (Clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign Tick = !Clear && (cnt_q == LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled, mid-bit majority vote, one-entry valid/ready output.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 1_000_000,
  parameter int BAUD_RATE       = 9600,
  parameter int OVERSAMPLE      = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic RxWire,
  uart_rx_if.master rx
);
  localparam int DIV = calc_div(CLOCK_FREQUENCY, BAUD_RATE, OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam logic [SCW-1:0] SC_LAST = SCW'(OVERSAMPLE - 1);
  localparam logic [SCW-1:0] SC_A    = SCW'(M - 1);
  localparam logic [SCW-1:0] SC_B    = SCW'(M);
  localparam logic [SCW-1:0] SC_C    = SCW'(M + 1);

  function automatic logic majority(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  rx_state_e      state_q, state_d;
  logic           sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic [2:0]     idx_q, idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           v0_q, v0_d, v1_q, v1_d, bit_q, bit_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d, fe_q, fe_d, ov_q, ov_d;
  logic           tick, maj, decide, bit_end;

  uart_rx_tick_gen #(.DIV(DIV)) u_tick (
    .Clk   (Clk),
    .Reset (Reset),
    .Clear (state_q == RX_IDLE),
    .Tick  (tick)
  );

  // Third vote is the live sample, so the decision lands on the sc == M+1 tick itself.
  assign maj     = majority(v0_q, v1_q, sync2_q);
  assign decide  = tick && (sc_q == SC_C);
  assign bit_end = tick && (sc_q == SC_LAST);

  always_comb begin
    state_d = state_q;
    sync1_d = RxWire;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    sc_d    = sc_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = valid_q;
    fe_d    = 1'b0;
    ov_d    = 1'b0;

    if (valid_q && rx.RxReady) begin
      valid_d = 1'b0;
    end

    if (tick) begin
      sc_d = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
      if (sc_q == SC_A) v0_d = sync2_q;
      if (sc_q == SC_B) v1_d = sync2_q;
      if (decide)       bit_d = maj;
    end

    case (state_q)
      RX_IDLE: begin
        sc_d = '0;
        // Falling edge only: a line held low after a frame cannot retrigger.
        if (!sync2_q && prev_q) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (decide && maj) begin
          state_d = RX_IDLE;
        end else if (bit_end) begin
          state_d = RX_DATA;
          idx_d   = 3'd0;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          shreg_d = {bit_q, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        // Leave at mid stop bit so a slightly fast sender's next start edge is caught.
        if (decide) begin
          state_d = RX_IDLE;
          if (!maj) begin
            fe_d = 1'b1;
          end else if (!valid_q || rx.RxReady) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ov_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= RX_IDLE;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      sc_q    <= '0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      bit_q   <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      sc_q    <= sc_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  assign rx.RxDataOutput = data_q;
  assign rx.RxValid      = valid_q;
  assign rx.RxFrameError = fe_q;
  assign rx.RxOverrun    = ov_q;
  assign rx.RxBusy       = (state_q != RX_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1.6 MHz / 10 kbaud / x16 (160 clocks per bit).
module tb_uart_rx;
  localparam int BITCLK = 160;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_wire = 1'b1;

  uart_rx_if rif ();

  uart_rx #(
    .CLOCK_FREQUENCY (1_600_000),
    .BAUD_RATE       (10_000),
    .OVERSAMPLE      (16)
  ) dut (
    .Clk    (clk),
    .Reset  (rst),
    .RxWire (rx_wire),
    .rx     (rif)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  int   fe_cnt = 0, ov_cnt = 0, both_cnt = 0, fall_cnt = 0;
  int   rise_cyc = -1;
  int   start_cyc = 0;
  logic vld_prev = 1'b0;

  always @(negedge clk) begin
    if (rif.RxValid && !vld_prev) rise_cyc = cyc;
    if (!rif.RxValid && vld_prev) fall_cnt++;
    vld_prev = rif.RxValid;
    if (rif.RxFrameError) fe_cnt++;
    if (rif.RxOverrun) ov_cnt++;
    if (rif.RxFrameError && rif.RxOverrun) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame from a negedge; optionally inverts clocks 86..95 of one data bit
  // and pulses RxReady on the cycle sampled by the stop-bit decision edge.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int spike_bit,
                            input bit rdy_pulse);
    logic v;
    start_cyc = cyc;
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < BITCLK; k++) begin
        if (b == 0)      v = 1'b0;
        else if (b == 9) v = stop_bit;
        else             v = d[b-1];
        if ((b - 1 == spike_bit) && k >= 86 && k < 96) v = ~v;
        rx_wire = v;
        if (rdy_pulse) rif.RxReady = (cyc == start_cyc + 1542);
        @(negedge clk);
      end
    end
  endtask

  task automatic consume();
    rif.RxReady = 1'b1;
    @(negedge clk);
    rif.RxReady = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int fe0, ov0, fl0, lat, c0;
    rif.RxReady = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_data",  {24'd0, rif.RxDataOutput}, 32'h00);
    chk("reset_valid", {31'd0, rif.RxValid}, 32'd0);
    chk("reset_fe",    {31'd0, rif.RxFrameError}, 32'd0);
    chk("reset_ov",    {31'd0, rif.RxOverrun}, 32'd0);
    chk("reset_busy",  {31'd0, rif.RxBusy}, 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 1: frame 0xA5, latency and hold
    fe0 = fe_cnt; ov0 = ov_cnt; fl0 = fall_cnt;
    send_frame(8'hA5, 1'b1, -1, 1'b0);
    rx_wire = 1'b1;
    lat = rise_cyc - start_cyc;
    checks++;
    assert ((lat >= 1541 && lat <= 1545) === 1'b1) else begin
      errors++;
      $error("FAIL t1_latency: observed=%0d expected=1543+-2", lat);
    end
    chk("t1_data",  {24'd0, rif.RxDataOutput}, 32'hA5);
    chk("t1_valid", {31'd0, rif.RxValid}, 32'd1);
    chk("t1_noerr", fe_cnt - fe0 + ov_cnt - ov0, 32'd0);
    repeat (500) @(negedge clk);
    chk("t1_hold_valid", {31'd0, rif.RxValid}, 32'd1);
    chk("t1_hold_data",  {24'd0, rif.RxDataOutput}, 32'hA5);
    chk("t1_no_fall",    fall_cnt - fl0, 32'd0);
    rif.RxReady = 1'b1;
    @(negedge clk);
    rif.RxReady = 1'b0;
    chk("t1_cleared", {31'd0, rif.RxValid}, 32'd0);
    repeat (50) @(negedge clk);

    // 2: 30-clock glitch is a false start
    fe0 = fe_cnt;
    c0 = cyc;
    rx_wire = 1'b0;
    repeat (5) @(negedge clk);
    chk("t2_busy_hi", {31'd0, rif.RxBusy}, 32'd1);
    repeat (25) @(negedge clk);
    rx_wire = 1'b1;
    repeat (74) @(negedge clk);
    chk("t2_elapsed", cyc - c0, 32'd104);
    chk("t2_busy_lo", {31'd0, rif.RxBusy}, 32'd0);
    repeat (200) @(negedge clk);
    chk("t2_no_valid", {31'd0, rif.RxValid}, 32'd0);
    chk("t2_no_fe",    fe_cnt - fe0, 32'd0);

    // 3: framing error then break
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0, -1, 1'b0);
    rx_wire = 1'b0;
    repeat (2 * 10 * BITCLK) @(negedge clk);
    chk("t3_fe_once",  fe_cnt - fe0, 32'd1);
    chk("t3_no_valid", {31'd0, rif.RxValid}, 32'd0);
    chk("t3_busy_lo",  {31'd0, rif.RxBusy}, 32'd0);
    rx_wire = 1'b1;
    repeat (400) @(negedge clk);

    // 4a: back-to-back, overrun on second
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, -1, 1'b0);
    send_frame(8'h22, 1'b1, -1, 1'b0);
    rx_wire = 1'b1;
    repeat (20) @(negedge clk);
    chk("t4a_data",  {24'd0, rif.RxDataOutput}, 32'h11);
    chk("t4a_valid", {31'd0, rif.RxValid}, 32'd1);
    chk("t4a_ov",    ov_cnt - ov0, 32'd1);
    chk("t4a_fe",    fe_cnt - fe0, 32'd0);
    consume();

    // 4b: consume and load on the same cycle
    ov0 = ov_cnt;
    send_frame(8'h11, 1'b1, -1, 1'b0);
    fl0 = fall_cnt;
    send_frame(8'h22, 1'b1, -1, 1'b1);
    rx_wire = 1'b1;
    rif.RxReady = 1'b0;
    repeat (20) @(negedge clk);
    chk("t4b_data",    {24'd0, rif.RxDataOutput}, 32'h22);
    chk("t4b_valid",   {31'd0, rif.RxValid}, 32'd1);
    chk("t4b_no_ov",   ov_cnt - ov0, 32'd0);
    chk("t4b_no_fall", fall_cnt - fl0, 32'd0);
    consume();

    // 5: spike on the middle sample of data bit 3
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h00, 1'b1, 3, 1'b0);
    rx_wire = 1'b1;
    repeat (20) @(negedge clk);
    chk("t5_data",  {24'd0, rif.RxDataOutput}, 32'h00);
    chk("t5_valid", {31'd0, rif.RxValid}, 32'd1);
    chk("t5_noerr", fe_cnt - fe0 + ov_cnt - ov0, 32'd0);

    // 6: reset during data bit 4, then a clean frame
    for (int b = 0; b < 6; b++) begin
      for (int k = 0; k < ((b == 5) ? 80 : BITCLK); k++) begin
        rx_wire = (b == 0) ? 1'b0 : ((8'h5A >> (b - 1)) & 8'h01) != 8'h00;
        @(negedge clk);
      end
    end
    chk("t6_busy_pre", {31'd0, rif.RxBusy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_busy",  {31'd0, rif.RxBusy}, 32'd0);
    chk("t6_rst_valid", {31'd0, rif.RxValid}, 32'd0);
    chk("t6_rst_data",  {24'd0, rif.RxDataOutput}, 32'h00);
    rx_wire = 1'b1;
    repeat (400) @(negedge clk);
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h5A, 1'b1, -1, 1'b0);
    rx_wire = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_data",  {24'd0, rif.RxDataOutput}, 32'h5A);
    chk("t6_valid", {31'd0, rif.RxValid}, 32'd1);
    chk("t6_noerr", fe_cnt - fe0 + ov_cnt - ov0, 32'd0);
    chk("never_fe_and_ov", both_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
